// File: rtl/imsic_pkg.sv
// Shared offsets, page geometry, queue entry layout and byte-swap helper for the IMSIC MSI router.
// A package cannot take parameters, so the entry layout is a macro the importer expands with its widths.
`define IMSIC_ENTRY_T(ID_W, FILE_W) struct packed { logic [(FILE_W)-1:0] file; logic [(ID_W)-1:0] id; }

package imsic_pkg;

    localparam int unsigned PAGE_SHIFT = 12;

    localparam logic [PAGE_SHIFT-1:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam logic [PAGE_SHIFT-1:0] SETEIPNUM_BE_OFF = 12'h004;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Posted-write queue: synchronous FIFO, pointers carry one extra wrap bit to tell full from empty.
module imsic_msi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/imsic_msi_router.sv
// Decodes MSI writes to M and S/VS interrupt-file pages, queues them, and drains one per cycle.
// Optional IMSIC_DROP_CNT_EN adds o_drop_cnt, a saturating count of writes dropped for bad identity.
module imsic_msi_router
    import imsic_pkg::*;
#(
    parameter int unsigned        NR_SRC_LEN            = 32,
    parameter int unsigned        NR_SRC                = 64,
    parameter int unsigned        NR_IMSICS             = 4,
    parameter int unsigned        NR_VS_FILES_PER_IMSIC = 1,
    parameter int unsigned        ADDR_W                = 32,
    parameter logic [ADDR_W-1:0]  M_BASE_ADDR           = ADDR_W'(32'h2400_0000),
    parameter logic [ADDR_W-1:0]  S_BASE_ADDR           = ADDR_W'(32'h2800_0000),
    parameter int unsigned        FIFO_DEPTH            = 4,
    localparam int unsigned       NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC
) (
    input  logic                                                    i_clk,
    input  logic                                                    ni_rst,
    input  logic                                                    i_req_valid,
    output logic                                                    o_req_ready,
    input  logic                                                    i_req_we,
    input  logic [ADDR_W-1:0]                                       i_req_addr,
    input  logic [31:0]                                             i_req_wdata,
    output logic                                                    o_rsp_valid,
    output logic                                                    o_rsp_err,
    output logic [31:0]                                             o_rsp_rdata,
    input  logic [NR_IMSICS*NR_INTP_FILES-1:0]                      i_file_busy,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0][NR_SRC_LEN-1:0] o_setipnum,
    output logic [NR_IMSICS-1:0][NR_INTP_FILES-1:0]                 o_setipnum_we
`ifdef IMSIC_DROP_CNT_EN
   ,output logic [15:0]                                             o_drop_cnt
`endif
);

    localparam int unsigned NR_FILES = NR_IMSICS * NR_INTP_FILES;
    localparam int unsigned FILE_W   = (NR_FILES > 1) ? $clog2(NR_FILES) : 1;
    localparam int unsigned NR_S     = NR_INTP_FILES - 1;
    localparam int unsigned G_W      = $clog2(NR_S);
    localparam int unsigned G        = 1 << G_W;

    typedef `IMSIC_ENTRY_T(NR_SRC_LEN, FILE_W) entry_t;
    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [ADDR_W-1:0]                  w_m_page, w_s_page, w_s_imsic, w_s_sub;
    logic                               w_m_hit, w_s_hit, w_hit;
    logic [PAGE_SHIFT-1:0]              w_off;
    logic                               w_le, w_be, w_fmt;
    logic [31:0]                        w_id32;
    logic                               w_id_ok;
    logic [FILE_W-1:0]                  w_file;
    logic                               w_accept, w_push, w_pop;
    logic                               w_full, w_empty;
    entry_t                             w_entry, w_head;
    logic [ENTRY_W-1:0]                 w_head_raw;
    logic [NR_FILES-1:0]                w_sel;
    logic                               r_ready_en;
    logic                               r_rsp_valid, r_rsp_err;
    logic [NR_FILES-1:0]                r_we;
    logic [NR_FILES-1:0][NR_SRC_LEN-1:0] r_setip;

    // M region: one page per IMSIC. S region: G pages per IMSIC, first NR_S of them populated.
    assign w_m_page  = (i_req_addr - M_BASE_ADDR) >> PAGE_SHIFT;
    assign w_s_page  = (i_req_addr - S_BASE_ADDR) >> PAGE_SHIFT;
    assign w_s_imsic = w_s_page >> G_W;
    assign w_s_sub   = w_s_page & ADDR_W'(G - 1);

    assign w_m_hit = (i_req_addr >= M_BASE_ADDR) && (w_m_page < ADDR_W'(NR_IMSICS));
    assign w_s_hit = (i_req_addr >= S_BASE_ADDR) && (w_s_imsic < ADDR_W'(NR_IMSICS))
                  && (w_s_sub < ADDR_W'(NR_S));
    assign w_hit   = w_m_hit || w_s_hit;

    always_comb begin
        w_file = '0;
        if (w_m_hit)
            w_file = FILE_W'(w_m_page * ADDR_W'(NR_INTP_FILES));
        else if (w_s_hit)
            w_file = FILE_W'(w_s_imsic * ADDR_W'(NR_INTP_FILES) + w_s_sub + ADDR_W'(1));
    end

    assign w_off   = i_req_addr[PAGE_SHIFT-1:0];
    assign w_le    = (w_off == SETEIPNUM_LE_OFF);
    assign w_be    = (w_off == SETEIPNUM_BE_OFF);
    assign w_fmt   = w_le || w_be;
    assign w_id32  = w_be ? bswap32(i_req_wdata) : i_req_wdata;
    assign w_id_ok = (w_id32 != '0) && (w_id32 < 32'(NR_SRC));

    assign o_req_ready = r_ready_en && !w_full;
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_push      = w_accept && i_req_we && w_hit && w_fmt && w_id_ok;
    assign w_entry     = '{file: w_file, id: NR_SRC_LEN'(w_id32)};

    imsic_msi_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head-of-line: a busy target holds back everything behind it.
    assign w_head = w_head_raw;
    assign w_pop  = !w_empty && !i_file_busy[w_head.file];

    for (genvar f = 0; f < NR_FILES; f++) begin : g_sel
        assign w_sel[f] = w_pop && (w_head.file == FILE_W'(f));
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            r_ready_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_we        <= '0;
            r_setip     <= '0;
        end else begin
            r_ready_en  <= 1'b1;
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && !w_hit;
            r_we        <= w_sel;
            for (int f = 0; f < NR_FILES; f++)
                r_setip[f] <= w_sel[f] ? w_head.id : '0;
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_rdata   = '0;
    assign o_setipnum_we = r_we;
    assign o_setipnum    = r_setip;

`ifdef IMSIC_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = w_accept && i_req_we && w_hit && w_fmt && !w_id_ok;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_imsic_msi_router.sv
// Randomized, self-checking bench for imsic_msi_router (2 IMSICs, 1 VS file, 64 ids, depth-4 queue).
module tb_imsic_msi_router;

    localparam int     NI   = 2;
    localparam int     NF   = 3;
    localparam int     NSRC = 64;
    localparam int     G    = 2;
    localparam longint M_BASE = 64'h2400_0000;
    localparam longint S_BASE = 64'h2800_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [NI*NF-1:0]             file_busy = '0;
    logic [NI-1:0][NF-1:0][31:0]  setipnum;
    logic [NI-1:0][NF-1:0]        setipnum_we;
`ifdef IMSIC_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    typedef struct { int idx; logic [31:0] id; } exp_t;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_drops = 0;
    bit   rnd_busy = 1'b0;

    always #5 clk = ~clk;

    imsic_msi_router #(
        .NR_SRC_LEN            (32),
        .NR_SRC                (NSRC),
        .NR_IMSICS             (NI),
        .NR_VS_FILES_PER_IMSIC (1),
        .ADDR_W                (32),
        .M_BASE_ADDR           (32'h2400_0000),
        .S_BASE_ADDR           (32'h2800_0000),
        .FIFO_DEPTH            (4)
    ) dut (
        .i_clk         (clk),
        .ni_rst        (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_err     (rsp_err),
        .o_rsp_rdata   (rsp_rdata),
        .i_file_busy   (file_busy),
        .o_setipnum    (setipnum),
        .o_setipnum_we (setipnum_we)
`ifdef IMSIC_DROP_CNT_EN
       ,.o_drop_cnt    (drop_cnt)
`endif
    );

    // Reference address map: which flat file (imsic*NF+file) a byte address lands in, if any.
    function automatic void ref_decode(input logic [31:0] a, output bit hit, output int idx, output int off);
        longint ua, p;
        ua  = longint'(a);
        hit = 1'b0;
        idx = 0;
        off = int'(ua % 4096);
        if (ua >= M_BASE && ua < M_BASE + NI * 4096) begin
            hit = 1'b1;
            idx = int'((ua - M_BASE) / 4096) * NF;
        end else if (ua >= S_BASE && ua < S_BASE + NI * G * 4096) begin
            p = (ua - S_BASE) / 4096;
            if (p % G < NF - 1) begin
                hit = 1'b1;
                idx = int'(p / G) * NF + int'(p % G) + 1;
            end
        end
    endfunction

    function automatic logic [31:0] ref_swap(input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
        return r;
    endfunction

    // One request: wait for ready (bounded), record model effect at the accepting edge, sample the response.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        output logic rv, output logic re, output logic [31:0] rd);
        int n;
        bit hit; int idx; int off; logic [31:0] id;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout addr=%h: ready=0 after %0d cycles, required 1", addr, n);
            req_valid = 1'b0; rv = 1'b0; re = 1'b0; rd = '0;
            return;
        end
        @(posedge clk);
        ref_decode(addr, hit, idx, off);
        if (we && hit && (off == 0 || off == 4)) begin
            id = (off == 4) ? ref_swap(data) : data;
            if (id != 0 && id < NSRC) exp_q.push_back('{idx, id});
            else if (model_drops < 65535) model_drops++;
        end
        #1 req_valid = 1'b0;
        @(negedge clk);
        rv = rsp_valid; re = rsp_err; rd = rsp_rdata;
    endtask

    // Every strobe must match the next expected message in order; idle slices stay zero.
    task automatic strobe_monitor();
        exp_t e; int hits; bit bad;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                hits = 0; bad = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    for (int f = 0; f < NF; f++) begin
                        if (setipnum_we[i][f]) begin
                            hits++; n_chk++;
                            if (exp_q.size() == 0) begin
                                n_fail++;
                                $display("FAIL strobe_unexpected file=%0d id=%0d, required no strobe", i*NF+f, setipnum[i][f]);
                            end else begin
                                e = exp_q.pop_front();
                                if (e.idx != i*NF+f || e.id !== setipnum[i][f]) begin
                                    n_fail++;
                                    $display("FAIL strobe_value got file=%0d id=%0d, required file=%0d id=%0d",
                                             i*NF+f, setipnum[i][f], e.idx, e.id);
                                end
                            end
                        end else if (setipnum[i][f] !== '0) bad = 1'b1;
                    end
                end
                n_chk++;
                if (hits > 1 || bad) begin
                    n_fail++;
                    $display("FAIL strobe_shape we=%b strobes=%0d idle_nonzero=%0d, required <=1 strobe and zero idle slices",
                             setipnum_we, hits, bad);
                end
            end
        end
    endtask

    task automatic busy_noise();
        forever begin
            @(negedge clk);
            if (rnd_busy) file_busy = 6'($urandom & $urandom);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b required 0", req_ready); end
        n_chk++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
            n_fail++; $display("FAIL rst_rsp got v=%b e=%b d=%h required 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        n_chk++; if (setipnum !== '0 || setipnum_we !== '0) begin
            n_fail++; $display("FAIL rst_setipnum got we=%b required 0", setipnum_we); end
`ifdef IMSIC_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop_cnt got %0d required 0", drop_cnt); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b required 1", req_ready); end
    endtask

    task automatic test_le_write();
        logic rv, re; logic [31:0] rd;
        send(1'b1, 32'h2800_3000, 32'd5, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL le_rsp got v=%b e=%b required 1/0", rv, re); end
        n_chk++; if (setipnum_we !== '0) begin n_fail++; $display("FAIL le_early got we=%b required 0", setipnum_we); end
        @(negedge clk);
        n_chk++; if (setipnum_we !== 6'b100000) begin n_fail++; $display("FAIL le_strobe got we=%b required 100000", setipnum_we); end
        n_chk++; if (setipnum[1][2] !== 32'd5) begin n_fail++; $display("FAIL le_id got %0d required 5", setipnum[1][2]); end
        @(negedge clk);
        n_chk++; if (setipnum_we !== '0) begin n_fail++; $display("FAIL le_oneshot got we=%b required 0", setipnum_we); end
    endtask

    task automatic test_be_write();
        logic rv, re; logic [31:0] rd;
        send(1'b1, 32'h2400_1004, 32'h0700_0000, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL be_rsp got v=%b e=%b required 1/0", rv, re); end
        @(negedge clk);
        n_chk++; if (setipnum_we[1][0] !== 1'b1 || setipnum[1][0] !== 32'd7) begin
            n_fail++; $display("FAIL be_swap got we=%b id=%h required 1/7", setipnum_we[1][0], setipnum[1][0]); end
    endtask

    task automatic test_bad_identity();
        logic rv, re; logic [31:0] rd; bit any;
        send(1'b1, 32'h2400_0000, 32'd0, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL id0_rsp got v=%b e=%b required 1/0", rv, re); end
        send(1'b1, 32'h2400_0000, 32'd64, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL id64_rsp got v=%b e=%b required 1/0", rv, re); end
        any = 1'b0;
        repeat (3) begin @(negedge clk); any |= |setipnum_we; end
        n_chk++; if (any) begin n_fail++; $display("FAIL badid_strobe got a strobe, required none"); end
`ifdef IMSIC_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 16'(model_drops)) begin
            n_fail++; $display("FAIL drop_cnt got %0d required %0d", drop_cnt, model_drops); end
`endif
    endtask

    task automatic test_decode_err();
        logic rv, re; logic [31:0] rd; bit any;
        send(1'b1, 32'h2800_4000, 32'd5, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b1) begin n_fail++; $display("FAIL oob_rsp got v=%b e=%b required 1/1", rv, re); end
        send(1'b0, 32'h2400_0000, 32'd5, rv, re, rd);
        n_chk++; if (rv !== 1'b1 || re !== 1'b0 || rd !== '0) begin
            n_fail++; $display("FAIL read_rsp got v=%b e=%b d=%h required 1/0/0", rv, re, rd); end
        any = 1'b0;
        repeat (3) begin @(negedge clk); any |= |setipnum_we; end
        n_chk++; if (any) begin n_fail++; $display("FAIL decode_strobe got a strobe, required none"); end
    endtask

    task automatic test_busy_backpressure();
        logic rv, re; logic [31:0] rd; logic [5:0] pat;
        file_busy = 6'b000001;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 32'h2400_0000, 32'($urandom_range(1, 63)), rv, re, rd);
            n_chk++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL bp_fill%0d got v=%b e=%b required 1/0", k, rv, re); end
        end
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b required 0", req_ready); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2400_0000; req_wdata = 32'd9;
        repeat (3) begin
            @(negedge clk);
            n_chk++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || setipnum_we !== '0) begin
                n_fail++; $display("FAIL bp_stall got rdy=%b rv=%b we=%b required 0/0/0", req_ready, rsp_valid, setipnum_we); end
        end
        req_valid = 1'b0;
        file_busy = '0;
        pat = '0;
        fork
            send(1'b1, 32'h2400_0000, 32'd9, rv, re, rd);
            for (int c = 0; c < 6; c++) begin @(negedge clk); pat[c] = setipnum_we[0][0]; end
        join
        n_chk++; if (pat !== 6'b011111) begin n_fail++; $display("FAIL bp_drain_pattern got %b required 011111", pat); end
        n_chk++; if (rv !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fifth got v=%b rdy=%b required 1/1", rv, req_ready); end
    endtask

    task automatic test_reset_midflight();
        logic rv, re; logic [31:0] rd; bit any;
        file_busy = 6'b000001;
        repeat (3) send(1'b1, 32'h2400_0000, 32'($urandom_range(1, 63)), rv, re, rd);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || setipnum_we !== '0 || setipnum !== '0) begin
            n_fail++; $display("FAIL midrst_outputs got rdy=%b rv=%b we=%b required all 0", req_ready, rsp_valid, setipnum_we); end
        exp_q.delete();
        model_drops = 0;
        file_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        repeat (6) begin @(negedge clk); any |= |setipnum_we; end
        n_chk++; if (any) begin n_fail++; $display("FAIL midrst_strobe got a strobe, required none"); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b required 1", req_ready); end
    endtask

    task automatic test_random();
        logic [31:0] tbl [13] = '{32'h2400_0000, 32'h2400_0004, 32'h2400_1000, 32'h2400_1004, 32'h2400_2000,
                                  32'h2800_0000, 32'h2800_1004, 32'h2800_2000, 32'h2800_3004, 32'h2800_4000,
                                  32'h2800_0008, 32'h23FF_F000, 32'h2400_0FFC};
        logic rv, re; logic [31:0] rd, a, d; logic we;
        bit hit; int idx, off, n;
        rnd_busy = 1'b1;
        for (int k = 0; k < 80; k++) begin
            a  = tbl[$urandom_range(0, 12)];
            we = ($urandom_range(0, 3) != 0);
            d  = 32'($urandom_range(0, 70));
            if (a[11:0] == 12'h004) d = ref_swap(d);
            if ($urandom_range(0, 7) == 0) d = $urandom;
            ref_decode(a, hit, idx, off);
            send(we, a, d, rv, re, rd);
            n_chk++; if (rv !== 1'b1 || re !== !hit || rd !== '0) begin
                n_fail++; $display("FAIL rnd_rsp addr=%h got v=%b e=%b d=%h required 1/%0d/0", a, rv, re, rd, !hit); end
        end
        rnd_busy = 1'b0;
        @(negedge clk);
        file_busy = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending required 0", exp_q.size()); end
`ifdef IMSIC_DROP_CNT_EN
        n_chk++; if (drop_cnt !== 16'(model_drops)) begin
            n_fail++; $display("FAIL rnd_drop_cnt got %0d required %0d", drop_cnt, model_drops); end
`endif
    endtask

    initial begin
        fork
            strobe_monitor();
            busy_noise();
        join_none
        test_reset();
        test_le_write();
        test_be_write();
        test_bad_identity();
        test_decode_err();
        test_busy_backpressure();
        test_reset_midflight();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
